// File: rtl/instr_prefetch_if.sv
// Bus bundle between the fetch front end, the instruction memory and the F stage.
interface instr_prefetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stallF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic        validF;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  stallF, redirect, redirect_pc,
    output instrF, pcF, validF
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output stallF, redirect, redirect_pc,
    input  instrF, pcF, validF
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: owns the fetch PC, keeps one request outstanding to a
// multi-cycle instruction memory and buffers returned words in a small FIFO.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  instr_prefetch_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   addr_q;
  logic          req_q;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          valid_q;
  logic [31:0]   instr_q;
  logic [31:0]   pc_q;
  logic [31:0]   mem_ins [DEPTH];
  logic [31:0]   mem_pc  [DEPTH];

  logic          push;
  logic          pop;
  logic          can_issue;
  logic [PW-1:0] rd_nxt;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] cnt_nxt;
  logic [31:0]   target;
  logic [31:0]   next_pc;

  // Next-cycle FIFO occupancy; issue is allowed only if a slot stays free for the response.
  always_comb begin
    target    = bus.redirect_pc & 32'hFFFF_FFFC;
    push      = (state == WAIT) && bus.imem_ack && !bus.redirect;
    pop       = valid_q && !bus.stallF && !bus.redirect;
    rd_nxt    = bus.redirect ? '0 : rd_ptr + PW'(pop);
    wr_nxt    = bus.redirect ? '0 : wr_ptr + PW'(push);
    cnt_nxt   = wr_nxt - rd_nxt;
    can_issue = cnt_nxt < PW'(DEPTH);
    next_pc   = fetch_pc;
    if (bus.redirect) begin
      next_pc = target;
    end else if (push) begin
      next_pc = fetch_pc + 32'd4;
    end
  end

  // Request FSM; a request is held until acked, a redirect only marks it for dropping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      fetch_pc <= next_pc;
      case (state)
        IDLE: begin
          if (can_issue) begin
            state  <= WAIT;
            req_q  <= 1'b1;
            addr_q <= next_pc;
          end
        end
        WAIT, DROP: begin
          if (bus.imem_ack) begin
            if (can_issue) begin
              state  <= WAIT;
              addr_q <= next_pc;
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end else if (bus.redirect) begin
            state <= DROP;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Pointers and registered head; the head register is loaded from the next-cycle view.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
    end else begin
      rd_ptr  <= rd_nxt;
      wr_ptr  <= wr_nxt;
      valid_q <= (cnt_nxt != '0);
      if (cnt_nxt == '0) begin
        instr_q <= 32'h0;
        pc_q    <= 32'h0;
      end else if (push && (rd_nxt == wr_ptr)) begin
        instr_q <= bus.imem_rdata;
        pc_q    <= fetch_pc;
      end else begin
        instr_q <= mem_ins[rd_nxt[AW-1:0]];
        pc_q    <= mem_pc[rd_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ins[wr_ptr[AW-1:0]] <= bus.imem_rdata;
      mem_pc[wr_ptr[AW-1:0]]  <= fetch_pc;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.validF    = valid_q;
  assign bus.instrF    = instr_q;
  assign bus.pcF       = pc_q;
endmodule
